// File: rtl/sc_schedule_ctrl.sv
// sc_schedule_ctrl: SC decoder stage/PE-block/fg schedule with handshake and delayed bit-index taps.
// Optional macro SC_SCHED_PERF_CNT_EN adds a decode_cycles cycle counter output.
module sc_schedule_ctrl #(
  parameter int N_LOG = 10,
  parameter int P_LOG = 6,
  parameter int DLY   = 2
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              hold,
`ifdef SC_SCHED_PERF_CNT_EN
  output logic [31:0]                                       decode_cycles,
`endif
  output logic                                              busy,
  output logic                                              done,
  output logic [$clog2(N_LOG)-1:0]                          stage_index,
  output logic [((N_LOG-1-P_LOG > 1) ? N_LOG-1-P_LOG : 1)-1:0] blk_index,
  output logic                                              fg_sel,
  output logic [N_LOG-1:0]                                  bit_index,
  output logic                                              bit_valid,
  output logic [DLY*N_LOG-1:0]                              bit_index_dly
);
  localparam int SW = $clog2(N_LOG);
  localparam int BW = (N_LOG-1-P_LOG > 1) ? N_LOG-1-P_LOG : 1;
  localparam int DW = DLY*N_LOG;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q;
  logic [SW-1:0]   stage_q;
  logic [BW-1:0]   blk_q, blk_max;
  logic            fg_q;
  logic [N_LOG-1:0] bit_q, bit_nx;
  logic [DW-1:0]   dly_q, dly_d;
  // lowest set bit of the next bit index is the stage where its g step starts
  function automatic logic [SW-1:0] ctz(input logic [N_LOG-1:0] v);
    ctz = '0;
    for (int k = N_LOG-1; k >= 0; k--) if (v[k]) ctz = SW'(k);
  endfunction
  always_comb begin
    blk_max = (32'(stage_q) > P_LOG) ? BW'((32'd1 << (32'(stage_q) - P_LOG)) - 32'd1) : '0;
    bit_nx = bit_q + 1'b1;
    dly_d = DW'({dly_q, bit_q});
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= SW'(N_LOG-1);
      blk_q   <= '0;
      fg_q    <= 1'b0;
      bit_q   <= '0;
      dly_q   <= '0;
    end else begin
      dly_q <= dly_d;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          stage_q <= SW'(N_LOG-1);
          blk_q   <= '0;
          fg_q    <= 1'b0;
          bit_q   <= '0;
        end
        RUN: if (!hold) begin
          if (blk_q != blk_max) blk_q <= blk_q + 1'b1;
          else if (stage_q != '0) begin
            stage_q <= stage_q - 1'b1;
            blk_q   <= '0;
            fg_q    <= 1'b0;
          end else begin
            blk_q   <= '0;
            bit_q   <= bit_nx;
            fg_q    <= ~&bit_q;
            stage_q <= &bit_q ? SW'(N_LOG-1) : ctz(bit_nx);
            if (&bit_q) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SC_SCHED_PERF_CNT_EN
  logic [31:0] cnt_q, dc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dc_q  <= '0;
    end else if (state_q == IDLE && start) cnt_q <= '0;
    else if (state_q == RUN) begin
      cnt_q <= cnt_q + 32'd1;
      if (bit_valid && &bit_q) dc_q <= cnt_q + 32'd1;
    end
  end
  assign decode_cycles = dc_q;
`endif
  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign stage_index   = stage_q;
  assign blk_index     = blk_q;
  assign fg_sel        = fg_q;
  assign bit_index     = bit_q;
  assign bit_index_dly = dly_q;
  assign bit_valid     = state_q == RUN && !hold && stage_q == '0 && blk_q == blk_max;
endmodule

// File: tb/tb_sc_schedule_ctrl.sv
// tb_sc_schedule_ctrl: directed checks of the schedule for N_LOG=3/P_LOG=1 and N_LOG=4/P_LOG=3.
module tb_sc_schedule_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0, hold_b = 1'b0;
  logic busy_a, done_a, fg_a, valid_a, blk_a;
  logic [1:0] stage_a;
  logic [2:0] bit_a;
  logic [5:0] dly_a;
  logic busy_b, done_b, fg_b, valid_b, blk_b;
  logic [1:0] stage_b;
  logic [3:0] bit_b;
  logic [7:0] dly_b;
`ifdef SC_SCHED_PERF_CNT_EN
  logic [31:0] dc_a, dc_b;
`endif
  int checks = 0, failures = 0;
  int stg_t[16] = '{2,2,1,0,0,1,0,0,2,2,1,0,0,1,0,0};
  int blk_t[16] = '{0,1,0,0,0,0,0,0,0,1,0,0,0,0,0,0};
  int fg_t[16]  = '{0,0,0,0,1,1,0,1,1,1,0,0,1,1,0,1};
  int bit_t[16] = '{0,0,0,0,1,2,2,3,4,4,4,4,5,6,6,7};

  always #5 clk = ~clk;

  sc_schedule_ctrl #(.N_LOG(3), .P_LOG(1), .DLY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
`ifdef SC_SCHED_PERF_CNT_EN
    .decode_cycles(dc_a),
`endif
    .busy(busy_a), .done(done_a), .stage_index(stage_a), .blk_index(blk_a),
    .fg_sel(fg_a), .bit_index(bit_a), .bit_valid(valid_a), .bit_index_dly(dly_a));

  sc_schedule_ctrl #(.N_LOG(4), .P_LOG(3), .DLY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
`ifdef SC_SCHED_PERF_CNT_EN
    .decode_cycles(dc_b),
`endif
    .busy(busy_b), .done(done_b), .stage_index(stage_b), .blk_index(blk_b),
    .fg_sel(fg_b), .bit_index(bit_b), .bit_valid(valid_b), .bit_index_dly(dly_b));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, done_a, valid_a, stage_a, blk_a, fg_a, bit_a, dly_a} !== {3'b000, 2'd2, 1'b0, 1'b0, 3'd0, 6'd0}) begin
      failures++;
      $display("FAIL reset_a: got busy=%b done=%b valid=%b stage=%0d blk=%0d fg=%b bit=%0d dly=%h, want 0 0 0 2 0 0 0 00",
               busy_a, done_a, valid_a, stage_a, blk_a, fg_a, bit_a, dly_a);
    end
    checks++;
    if ({busy_b, done_b, stage_b, bit_b, dly_b} !== {2'b00, 2'd3, 4'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_b: got busy=%b done=%b stage=%0d bit=%0d dly=%h, want 0 0 3 0 00",
               busy_b, done_b, stage_b, bit_b, dly_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one codeword on dut_a; optional hold window (in RUN cycles) and a start pulse while busy.
  task automatic run_cw(input string name, input int hold_at, input int hold_len, input bit pulse_start);
    int j = 0, t = 0;
    logic [8:0] got, exp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (j < 16 && t < 64) begin
      hold_a = (t >= hold_at && t < hold_at + hold_len);
      start_a = pulse_start && t == 5;
      #1;
      got = {busy_a, stage_a, blk_a, fg_a, bit_a, valid_a};
      exp = {1'b1, 2'(stg_t[j]), 1'(blk_t[j]), 1'(fg_t[j]), 3'(bit_t[j]), stg_t[j] == 0 && !hold_a};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_cycle%0d: got busy/stage/blk/fg/bit/valid=%b, want %b", name, t, got, exp);
      end
      if (!hold_a) j++;
      t++;
      @(negedge clk);
    end
    hold_a = 1'b0;
    start_a = 1'b0;
    #1;
    checks++;
    if ({done_a, busy_a, valid_a} !== 3'b100 || t != 16 + hold_len) begin
      failures++;
      $display("FAIL %s_done: got done=%b busy=%b valid=%b run_cycles=%0d, want 1 0 0 %0d",
               name, done_a, busy_a, valid_a, t, 16 + hold_len);
    end
`ifdef SC_SCHED_PERF_CNT_EN
    checks++;
    if (dc_a !== 32'(16 + hold_len)) begin
      failures++;
      $display("FAIL %s_decode_cycles: got %0d, want %0d", name, dc_a, 16 + hold_len);
    end
`endif
    @(negedge clk);
    checks++;
    if ({done_a, busy_a, stage_a, bit_a} !== {2'b00, 2'd2, 3'd0}) begin
      failures++;
      $display("FAIL %s_idle: got done=%b busy=%b stage=%0d bit=%0d, want 0 0 2 0", name, done_a, busy_a, stage_a, bit_a);
    end
  endtask

  task automatic test_basic();
    run_cw("basic", 99, 0, 1'b0);
  endtask

  task automatic test_hold();
    run_cw("hold", 2, 3, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_cw("restart", 99, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_cw("b2b_first", 99, 0, 1'b0);
    run_cw("b2b_second", 99, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bit saw_done = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = done_a;
    checks++;
    if ({busy_a, done_a, stage_a, bit_a, dly_a} !== {2'b00, 2'd2, 3'd0, 6'd0}) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b done=%b stage=%0d bit=%0d dly=%h, want 0 0 2 0 00",
               busy_a, done_a, stage_a, bit_a, dly_a);
    end
    repeat (3) begin
      @(negedge clk);
      saw_done |= done_a | busy_a;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done: got done_or_busy=%b, want 0", saw_done);
    end
  endtask

  task automatic test_wide_pe();
    int t = 0, nbusy = 0, nvalid = 0, ninc = 0;
    logic [3:0] h1 = bit_b, h2 = bit_b;
    @(negedge clk);
    h2 = h1;
    h1 = bit_b;
    start_b = 1'b1;
    while (!done_b && t < 100) begin
      @(negedge clk);
      start_b = 1'b0;
      if (busy_b && nbusy == 0) begin
        checks++;
        if ({stage_b, blk_b, fg_b} !== {2'd3, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL wide_first: got stage=%0d blk=%0d fg=%b, want 3 0 0", stage_b, blk_b, fg_b);
        end
      end
      if (busy_b && nbusy == 1) begin
        checks++;
        if (stage_b !== 2'd2) begin
          failures++;
          $display("FAIL wide_second: got stage=%0d, want 2", stage_b);
        end
      end
      if (bit_b != h1) begin
        ninc++;
        checks++;
        if (dly_b[7:4] !== h2) begin
          failures++;
          $display("FAIL wide_tap1: got %0d, want %0d", dly_b[7:4], h2);
        end
      end
      nbusy += busy_b;
      nvalid += valid_b;
      h2 = h1;
      h1 = bit_b;
      t++;
    end
    checks++;
    if (nbusy != 30 || nvalid != 16 || ninc != 16 || done_b !== 1'b1) begin
      failures++;
      $display("FAIL wide_totals: got busy=%0d valid=%0d incs=%0d done=%b, want 30 16 16 1", nbusy, nvalid, ninc, done_b);
    end
`ifdef SC_SCHED_PERF_CNT_EN
    checks++;
    if (dc_b !== 32'd30) begin
      failures++;
      $display("FAIL wide_decode_cycles: got %0d, want 30", dc_b);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_mid_reset();
    test_wide_pe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
